// File: rtl/data_stream_chk_if.sv
// Serial stream checker bus: raw line in, recovered bits and lock status out.
// master = stimulus side, slave = checker side.
interface data_stream_chk_if #(
   parameter int ERR_W = 16
);
   logic             data_in;
   logic             clear_in;
   logic             bit_valid;
   logic             bit_out;
   logic             locked;
   logic             frame_ok;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output data_in, clear_in,
      input  bit_valid, bit_out, locked, frame_ok, err_cnt
   );

   modport slave (
      input  data_in, clear_in,
      output bit_valid, bit_out, locked, frame_ok, err_cnt
   );
endinterface

// File: rtl/data_stream_chk.sv
// Oversampling bit recovery plus frame lock/error checker for a fixed pattern.
// Ports: clk, reset (async, active high), bus (data_in/clear_in in, status out).
module data_stream_chk #(
   parameter int                    STREAM_LEN  = 8,
   parameter logic [STREAM_LEN-1:0] BIT_STREAM  = 8'b10101010,
   parameter int                    HOLD_CYCLES = 10,
   parameter int                    LOSS_THRESH = 2,
   parameter int                    ERR_W       = 16
) (
   input logic              clk,
   input logic              reset,
   data_stream_chk_if.slave bus
);
   localparam int PH_W   = $clog2(HOLD_CYCLES);
   localparam int IDX_W  = $clog2(STREAM_LEN);
   localparam int FILL_W = $clog2(STREAM_LEN + 1);
   localparam int FM_W   = $clog2(LOSS_THRESH + 1);

   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HOLD_CYCLES - 1);
   localparam logic [PH_W-1:0]   PH_MID    = PH_W'(HOLD_CYCLES / 2);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(STREAM_LEN - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(STREAM_LEN);
   localparam logic [FM_W-1:0]   FM_LOSS   = FM_W'(LOSS_THRESH);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t                  state;
   logic                    s1, s2, s3;
   logic [PH_W-1:0]         ph;
   logic [STREAM_LEN-1:0]   sr;
   logic [FILL_W-1:0]       fill;
   logic [IDX_W-1:0]        idx;
   logic [FM_W-1:0]         fm;
   logic                    bit_valid_q;
   logic                    bit_out_q;
   logic                    frame_ok_q;
   logic [ERR_W-1:0]        err_q;

   logic                    edge_seen;
   logic                    sample;
   logic                    exp_bit;
   logic                    mism;
   logic [FM_W-1:0]         fm_next;

   assign edge_seen = s2 ^ s3;
   // Mid-bit sample, skipped on a transition so the eye is re-centred first.
   assign sample    = (ph == PH_MID) && !edge_seen;
   assign exp_bit   = BIT_STREAM[IDX_LAST - idx];
   // The registered sample is judged one cycle after it is taken.
   assign mism      = bit_valid_q && (state == LOCKED) &&
                      (bit_out_q != exp_bit);
   assign fm_next   = fm + FM_W'(mism);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         ph          <= '0;
         sr          <= '0;
         fill        <= '0;
         idx         <= '0;
         fm          <= '0;
         state       <= SEARCH;
         bit_valid_q <= 1'b0;
         bit_out_q   <= 1'b0;
         frame_ok_q  <= 1'b0;
         err_q       <= '0;
      end else begin
         s1 <= bus.data_in;
         s2 <= s1;
         s3 <= s2;

         if (edge_seen || ph == PH_LAST) ph <= '0;
         else                            ph <= ph + 1'b1;

         bit_valid_q <= sample;
         frame_ok_q  <= 1'b0;

         if (sample) begin
            bit_out_q <= s2;
            sr        <= {sr[STREAM_LEN-2:0], s2};
            if (fill != FILL_FULL) fill <= fill + 1'b1;
         end

         if (bus.clear_in)               err_q <= '0;
         else if (mism && err_q != '1)   err_q <= err_q + 1'b1;

         if (bit_valid_q) begin
            unique case (state)
               SEARCH: begin
                  if (fill == FILL_FULL && sr == BIT_STREAM) begin
                     state      <= LOCKED;
                     idx        <= '0;
                     fm         <= '0;
                     frame_ok_q <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (fm_next == FM_LOSS) begin
                     // Drop lock; a fresh full-length match is needed.
                     state <= SEARCH;
                     fill  <= '0;
                     fm    <= '0;
                     idx   <= '0;
                  end else if (idx == IDX_LAST) begin
                     idx        <= '0;
                     fm         <= '0;
                     frame_ok_q <= (fm_next == '0);
                  end else begin
                     idx <= idx + 1'b1;
                     fm  <= fm_next;
                  end
               end
               default: state <= SEARCH;
            endcase
         end
      end
   end

   assign bus.bit_valid = bit_valid_q;
   assign bus.bit_out   = bit_out_q;
   assign bus.locked    = (state == LOCKED);
   assign bus.frame_ok  = frame_ok_q;
   assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_data_stream_chk.sv
// Directed bench for data_stream_chk: default instance plus a 2-bit
// error counter instance fed the same stream.
module tb_data_stream_chk;
   localparam logic [7:0] PAT = 8'b10101010;

   logic clk = 1'b0;
   logic reset;

   data_stream_chk_if #(.ERR_W(16)) ifa ();
   data_stream_chk_if #(.ERR_W(2))  ifb ();

   data_stream_chk dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   data_stream_chk #(.ERR_W(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int nbv   = 0;
   int nfok  = 0;
   int n_one = 0;

   always @(negedge clk) begin
      if (ifa.bit_valid === 1'b1) begin
         nbv++;
         if (ifa.bit_out === 1'b1) n_one++;
      end
      if (ifa.frame_ok === 1'b1) nfok++;
   end

   typedef struct {
      logic [7:0] flip;
      int         fok;
      logic       lck;
      int         ea;
      int         eb;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic b);
      ifa.data_in = b;
      ifb.data_in = b;
   endtask

   task automatic drive_clear(input logic c);
      ifa.clear_in = c;
      ifb.clear_in = c;
   endtask

   task automatic send_bit(input logic b);
      drive(b);
      repeat (10) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] flip);
      for (int j = 7; j >= 0; j--) send_bit(PAT[j] ^ flip[j]);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_a"}, 32'({ifa.bit_valid, ifa.bit_out,
                             ifa.locked, ifa.frame_ok}), 0);
      chk({name, "_ea"}, 32'(ifa.err_cnt), 0);
      chk({name, "_b"}, 32'({ifb.bit_valid, ifb.bit_out,
                            ifb.locked, ifb.frame_ok}), 0);
      chk({name, "_eb"}, 32'(ifb.err_cnt), 0);
   endtask

   initial begin
      int b0, f0, o0;

      tbl[0]  = '{8'h00, 1, 1'b1, 0, 0};
      tbl[1]  = '{8'h00, 1, 1'b1, 0, 0};
      tbl[2]  = '{8'h08, 0, 1'b1, 1, 1};
      tbl[3]  = '{8'h00, 1, 1'b1, 1, 1};
      tbl[4]  = '{8'h01, 0, 1'b1, 2, 2};
      tbl[5]  = '{8'h80, 0, 1'b1, 3, 3};
      tbl[6]  = '{8'h10, 0, 1'b1, 4, 3};
      tbl[7]  = '{8'h02, 0, 1'b1, 5, 3};
      tbl[8]  = '{8'h24, 0, 1'b0, 7, 3};
      tbl[9]  = '{8'h00, 1, 1'b1, 7, 3};
      tbl[10] = '{8'h00, 1, 1'b1, 7, 3};
      tbl[11] = '{8'h00, 1, 1'b1, 7, 3};

      reset = 1'b1;
      drive(1'b0);
      drive_clear(1'b0);
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      // Line idle at 0: free-running sampling, no lock, no errors.
      b0 = nbv;
      o0 = n_one;
      repeat (100) @(negedge clk);
      #1;
      chk("idle_bits", 32'(nbv - b0), 10);
      chk("idle_ones", 32'(n_one - o0), 0);
      chk("idle_lock", 32'(ifa.locked), 0);
      chk("idle_err", 32'(ifa.err_cnt), 0);

      for (int i = 0; i < 12; i++) begin
         b0 = nbv;
         f0 = nfok;
         send_frame(tbl[i].flip);
         #1;
         if (i > 0) chk($sformatf("bits%0d", i), 32'(nbv - b0), 8);
         chk($sformatf("fok%0d", i), 32'(nfok - f0), 32'(tbl[i].fok));
         chk($sformatf("lock%0d", i), 32'(ifa.locked), 32'(tbl[i].lck));
         chk($sformatf("erra%0d", i), 32'(ifa.err_cnt), 32'(tbl[i].ea));
         chk($sformatf("errb%0d", i), 32'(ifb.err_cnt), 32'(tbl[i].eb));
      end

      // Clear coincident with a mismatch: clear wins.
      for (int j = 7; j >= 0; j--) begin
         if (j == 4) begin
            drive(~PAT[j]);
            repeat (9) @(negedge clk);
            chk("lat_valid", 32'(ifa.bit_valid), 1);
            chk("lat_bit", 32'(ifa.bit_out), 1);
            drive_clear(1'b1);
            @(negedge clk);
            drive_clear(1'b0);
            chk("clrwin_a", 32'(ifa.err_cnt), 0);
            chk("clrwin_b", 32'(ifb.err_cnt), 0);
         end else begin
            send_bit(PAT[j]);
         end
      end
      #1;
      chk("clr_lock", 32'(ifa.locked), 1);

      send_frame(8'h40);
      #1;
      chk("after_clr_a", 32'(ifa.err_cnt), 1);
      chk("after_clr_b", 32'(ifb.err_cnt), 1);
      chk("after_clr_lock", 32'(ifa.locked), 1);

      // Reset mid-frame while locked.
      send_bit(PAT[7]);
      send_bit(PAT[6]);
      send_bit(PAT[5]);
      chk("pre_rst_lock", 32'(ifa.locked), 1);
      reset = 1'b1;
      drive(1'b0);
      #1;
      chk_zero("midrst");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      f0 = nfok;
      for (int j = 7; j >= 1; j--) send_bit(PAT[j]);
      #1;
      chk("relock_early", 32'(ifa.locked), 0);
      send_bit(PAT[0]);
      #1;
      chk("relock", 32'(ifa.locked), 1);
      chk("relock_fok", 32'(nfok - f0), 1);
      chk("relock_err", 32'(ifa.err_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
